// File: rtl/mux8_sel_sequencer_pkg.sv
// mux8_seq_pkg: shared types, sizes and LFSR step for the mux8 select sequencer
package mux8_seq_pkg;
  typedef enum logic {IDLE, SCAN} seq_state_t;
  localparam int SEL_W = 3;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/mux8_sel_sequencer_if.sv
// mux8_sel_sequencer_if: bank write port, scan control and output stream of the sequencer
interface mux8_sel_sequencer_if #(parameter int N = 64);
  import mux8_seq_pkg::*;
  logic wr_valid, wr_ready;
  logic [SEL_W-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic start, rand_mode;
  logic [SEL_W-1:0] start_sel;
  logic [CNT_W-1:0] len_m1;
  logic out_valid, out_ready, out_last, busy;
  logic [N-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  modport master(
    output wr_valid, wr_addr, wr_data, start, start_sel, len_m1, rand_mode, out_ready,
    input wr_ready, out_valid, out_data, out_sel, out_last, busy
  );
  modport slave(
    input wr_valid, wr_addr, wr_data, start, start_sel, len_m1, rand_mode, out_ready,
    output wr_ready, out_valid, out_data, out_sel, out_last, busy
  );
endinterface

// File: rtl/mux8_sel_sequencer_mux.sv
// testmux8: plain combinational 8:1 mux of N-bit words
module testmux8 #(parameter int N = 64) (
  input  logic [N-1:0] d [8],
  input  logic [2:0]   sel,
  output logic [N-1:0] y
);
  assign y = d[sel];
endmodule

// File: rtl/mux8_sel_sequencer.sv
// mux8_sel_sequencer: loads an 8-entry bank, then streams a handshaked select scan through testmux8.
// Define LFSR_SEL_EN to allow LFSR-driven select stepping via rand_mode.
module mux8_sel_sequencer
  import mux8_seq_pkg::*;
#(
  parameter int N = 64,
  parameter logic [7:0] SEED = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  mux8_sel_sequencer_if.slave bus
);
  seq_state_t state;
  logic [SEL_W-1:0] sel, nxt_sel;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] bank [DEPTH];
  logic hs;
  assign hs = state == SCAN && bus.out_ready;
`ifdef LFSR_SEL_EN
  logic [7:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = lfsr_step(lfsr);
  assign nxt_sel = bus.rand_mode ? lfsr_nxt[SEL_W-1:0] : sel + SEL_W'(1);
  // only ever seeded by reset so successive scans continue the sequence
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= SEED;
    else if (hs && bus.rand_mode) lfsr <= lfsr_nxt;
`else
  assign nxt_sel = sel + SEL_W'(1);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (state == IDLE) begin
      if (bus.wr_valid) bank[bus.wr_addr] <= bus.wr_data;
      if (bus.start) begin
        state <= SCAN;
        sel <= bus.start_sel;
        cnt <= bus.len_m1;
      end
    end else if (hs) begin
      sel <= nxt_sel;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) state <= IDLE;
    end
  assign bus.wr_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == SCAN;
  assign bus.out_last = state == SCAN && cnt == '0;
  assign bus.out_sel = sel;
  testmux8 #(.N(N)) u_mux (.d(bank), .sel(sel), .y(bus.out_data));
endmodule
